// File: rtl/sd_cmd_sequencer_if.sv
// rtl/sd_cmd_sequencer_if.sv - handshake bundle between UART paths, sequencer and SD driver
interface sd_cmd_sequencer_if;
  // UART receive path
  logic        RX_STB;
  logic [7:0]  RX_DAT;
  // SD driver write request channel
  logic        WR_STB;
  logic [31:0] WR_ADDR;
  logic [7:0]  WR_LENGTH;
  logic        WR_ACK;
  // SD driver read request channel
  logic        RD_STB;
  logic [31:0] RD_ADDR;
  logic [7:0]  RD_LENGTH;
  logic        RD_ACK;
  // UART transmit path status byte
  logic        ST_STB;
  logic [7:0]  ST_DAT;
  logic        ST_ACK;
  // sequencer activity
  logic        BUSY;

  // sequencer side
  modport master (
    input  RX_STB, RX_DAT, WR_ACK, RD_ACK, ST_ACK,
    output WR_STB, WR_ADDR, WR_LENGTH,
    output RD_STB, RD_ADDR, RD_LENGTH,
    output ST_STB, ST_DAT, BUSY
  );

  // environment side (UART paths and SD driver)
  modport slave (
    output RX_STB, RX_DAT, WR_ACK, RD_ACK, ST_ACK,
    input  WR_STB, WR_ADDR, WR_LENGTH,
    input  RD_STB, RD_ADDR, RD_LENGTH,
    input  ST_STB, ST_DAT, BUSY
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - parses UART command frames into one acknowledged SD read/write request
//
// Frame: opcode ('w' / 'r'), ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], LEN.
// Exactly one request strobe per valid frame, then one status byte to the UART
// transmit path. Bytes arriving while a request or status is outstanding are dropped.
module sd_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned BYTE_TIMEOUT   = 5000000
) (
  input  logic               CLOCK50,
  input  logic               nRESET,
  sd_cmd_sequencer_if.master bus
);

  localparam logic [7:0] OP_WR   = 8'h77;  // 'w'
  localparam logic [7:0] OP_RD   = 8'h72;  // 'r'
  localparam logic [7:0] ST_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] ST_TMO  = 8'h54;  // 'T'
  localparam logic [7:0] ST_LEN0 = 8'h45;  // 'E'
  localparam logic [7:0] ST_GAP  = 8'h46;  // 'F'
  localparam logic [7:0] ST_UNK  = 8'h3F;  // '?'

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(BYTE_TIMEOUT + 1);

  // Counters start at 0 in the first waiting cycle, so the last permitted
  // waiting cycle is seen when the count reaches LIMIT-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};
  localparam logic [GW-1:0] GAP_LAST = GW'(BYTE_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MAX  = {GW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_ISSUE,
    S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic          op_wr_q, op_wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_stb_q, wr_stb_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_len_q, wr_len_d;
  logic          rd_stb_q, rd_stb_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [7:0]    rd_len_q, rd_len_d;
  logic          st_stb_q, st_stb_d;
  logic [7:0]    st_dat_q, st_dat_d;
  logic          active_ack;

  // Only the channel that was actually requested may complete the request.
  assign active_ack = op_wr_q ? bus.WR_ACK : bus.RD_ACK;

  // Frame parser, request issue and status report sequencing
  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    wr_stb_d  = wr_stb_q;
    wr_addr_d = wr_addr_q;
    wr_len_d  = wr_len_q;
    rd_stb_d  = rd_stb_q;
    rd_addr_d = rd_addr_q;
    rd_len_d  = rd_len_q;
    st_stb_d  = st_stb_q;
    st_dat_d  = st_dat_q;

    case (state_q)
      S_IDLE: begin
        if (bus.RX_STB) begin
          if (bus.RX_DAT == OP_WR || bus.RX_DAT == OP_RD) begin
            op_wr_d = (bus.RX_DAT == OP_WR);
            addr_d  = '0;
            cnt_d   = '0;
            gap_d   = '0;
            state_d = S_ADDR;
          end else begin
            st_stb_d = 1'b1;
            st_dat_d = ST_UNK;
            state_d  = S_REPORT;
          end
        end
      end

      S_ADDR: begin
        if (bus.RX_STB) begin
          addr_d = {addr_q[23:0], bus.RX_DAT};
          cnt_d  = cnt_q + 2'd1;
          gap_d  = '0;
          if (cnt_q == 2'd3) begin
            state_d = S_LEN;
          end
        end else if (gap_q >= GAP_LAST) begin
          st_stb_d = 1'b1;
          st_dat_d = ST_GAP;
          state_d  = S_REPORT;
        end else if (gap_q != GAP_MAX) begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_LEN: begin
        if (bus.RX_STB) begin
          gap_d = '0;
          if (bus.RX_DAT == 8'h00) begin
            st_stb_d = 1'b1;
            st_dat_d = ST_LEN0;
            state_d  = S_REPORT;
          end else begin
            tmo_d = '0;
            if (op_wr_q) begin
              wr_addr_d = addr_q;
              wr_len_d  = bus.RX_DAT;
              wr_stb_d  = 1'b1;
            end else begin
              rd_addr_d = addr_q;
              rd_len_d  = bus.RX_DAT;
              rd_stb_d  = 1'b1;
            end
            state_d = S_ISSUE;
          end
        end else if (gap_q >= GAP_LAST) begin
          st_stb_d = 1'b1;
          st_dat_d = ST_GAP;
          state_d  = S_REPORT;
        end else if (gap_q != GAP_MAX) begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_ISSUE: begin
        // ACK is checked before the timeout so a same-cycle ACK still reports 'K'.
        if (active_ack) begin
          wr_stb_d = 1'b0;
          rd_stb_d = 1'b0;
          st_stb_d = 1'b1;
          st_dat_d = ST_OK;
          state_d  = S_REPORT;
        end else if (tmo_q >= TMO_LAST) begin
          wr_stb_d = 1'b0;
          rd_stb_d = 1'b0;
          st_stb_d = 1'b1;
          st_dat_d = ST_TMO;
          state_d  = S_REPORT;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_REPORT: begin
        if (bus.ST_ACK) begin
          st_stb_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        wr_stb_d = 1'b0;
        rd_stb_d = 1'b0;
        st_stb_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every strobe without sending status
  always_ff @(posedge CLOCK50 or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      rd_stb_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      st_stb_q  <= 1'b0;
      st_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_len_q  <= wr_len_d;
      rd_stb_q  <= rd_stb_d;
      rd_addr_q <= rd_addr_d;
      rd_len_q  <= rd_len_d;
      st_stb_q  <= st_stb_d;
      st_dat_q  <= st_dat_d;
    end
  end

  assign bus.WR_STB    = wr_stb_q;
  assign bus.WR_ADDR   = wr_addr_q;
  assign bus.WR_LENGTH = wr_len_q;
  assign bus.RD_STB    = rd_stb_q;
  assign bus.RD_ADDR   = rd_addr_q;
  assign bus.RD_LENGTH = rd_len_q;
  assign bus.ST_STB    = st_stb_q;
  assign bus.ST_DAT    = st_dat_q;
  assign bus.BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - randomized self-checking bench for sd_cmd_sequencer
module tb_sd_cmd_sequencer;

  localparam int TMO = 100;
  localparam int BT  = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_sequencer_if bus();

  sd_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .BYTE_TIMEOUT(BT)) dut (
    .CLOCK50(clk),
    .nRESET (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference view of the retained request registers
  logic [31:0] m_wr_addr = '0;
  logic [7:0]  m_wr_len  = '0;
  logic [31:0] m_rd_addr = '0;
  logic [7:0]  m_rd_len  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_STB = 1'b1;
    bus.RX_DAT = b;
    tick();
    bus.RX_STB = 1'b0;
    bus.RX_DAT = 8'($urandom);
  endtask

  // status the frame must produce, derived from the frame rules alone
  function automatic logic [7:0] exp_status(input logic [7:0] op, input logic [7:0] len, input int d);
    if (op != "w" && op != "r") return "?";
    if (len == 0) return "E";
    if (d >= 1 && d <= TMO) return "K";
    return "T";
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_wr_addr"}, bus.WR_ADDR, m_wr_addr);
    chk({tag, "_wr_len"}, bus.WR_LENGTH, m_wr_len);
    chk({tag, "_rd_addr"}, bus.RD_ADDR, m_rd_addr);
    chk({tag, "_rd_len"}, bus.RD_LENGTH, m_rd_len);
  endtask

  // we are in the first cycle status should be visible; hold it a few cycles, then consume
  task automatic take_status(input logic [7:0] code, input string tag);
    int w;
    w = $urandom_range(0, 3);
    chk({tag, "_st_stb"}, bus.ST_STB, 1);
    chk({tag, "_st_dat"}, bus.ST_DAT, code);
    chk({tag, "_busy"}, bus.BUSY, 1);
    chk({tag, "_wr_stb_off"}, bus.WR_STB, 0);
    chk({tag, "_rd_stb_off"}, bus.RD_STB, 0);
    for (int i = 0; i < w; i++) begin
      bus.RX_STB = 1'b1;
      bus.RX_DAT = "w";
      tick();
      bus.RX_STB = 1'b0;
      chk({tag, "_st_hold"}, bus.ST_STB, 1);
      chk({tag, "_st_dat_hold"}, bus.ST_DAT, code);
    end
    bus.ST_ACK = 1'b1;
    tick();
    bus.ST_ACK = 1'b0;
    chk({tag, "_st_drop"}, bus.ST_STB, 0);
    chk({tag, "_idle"}, bus.BUSY, 0);
  endtask

  // gap < 0: random inter-byte idle in 0..BT-1, otherwise exactly gap idle cycles
  task automatic do_frame(input logic [7:0] op, input logic [31:0] addr, input logic [7:0] len,
                          input int d, input int gap, input bit noise, input string tag);
    logic [7:0] code;
    logic [7:0] fb[5];
    bit         is_wr;
    int         cnt;
    int         exp_cnt;
    logic       s;
    logic       o;
    code  = exp_status(op, len, d);
    fb    = '{addr[31:24], addr[23:16], addr[15:8], addr[7:0], len};
    send_byte(op);
    if (code == "?") begin
      take_status(code, tag);
      check_regs(tag);
      return;
    end
    for (int i = 0; i < 5; i++) begin
      repeat ((gap < 0) ? $urandom_range(0, BT - 1) : gap) tick();
      send_byte(fb[i]);
    end
    if (code == "E") begin
      take_status(code, tag);
      check_regs(tag);
      return;
    end
    is_wr = (op == "w");
    if (is_wr) begin
      m_wr_addr = addr;
      m_wr_len  = len;
    end else begin
      m_rd_addr = addr;
      m_rd_len  = len;
    end
    exp_cnt = (code == "K") ? d : TMO;
    cnt = 0;
    for (int cyc = 0; cyc < TMO + 20; cyc++) begin
      s = is_wr ? bus.WR_STB : bus.RD_STB;
      o = is_wr ? bus.RD_STB : bus.WR_STB;
      chk({tag, "_other_stb"}, o, 0);
      if (!s) break;
      cnt++;
      chk({tag, "_req_addr"}, is_wr ? bus.WR_ADDR : bus.RD_ADDR, addr);
      chk({tag, "_req_len"}, is_wr ? bus.WR_LENGTH : bus.RD_LENGTH, len);
      if (cnt == d) begin
        if (is_wr) bus.WR_ACK = 1'b1;
        else       bus.RD_ACK = 1'b1;
      end
      if (noise) begin
        if (is_wr) bus.RD_ACK = 1'($urandom_range(0, 1));
        else       bus.WR_ACK = 1'($urandom_range(0, 1));
        bus.RX_STB = 1'($urandom_range(0, 1));
        bus.RX_DAT = "x";
      end
      tick();
      bus.WR_ACK = 1'b0;
      bus.RD_ACK = 1'b0;
      bus.RX_STB = 1'b0;
    end
    chk({tag, "_stb_cycles"}, cnt, exp_cnt);
    take_status(code, tag);
    check_regs(tag);
  endtask

  // opcode plus nb further bytes, then silence until the gap timer fires
  task automatic gap_abort(input logic [7:0] op, input int nb, input string tag);
    send_byte(op);
    for (int i = 0; i < nb; i++) send_byte(8'($urandom));
    repeat (BT - 1) tick();
    chk({tag, "_before_gap"}, bus.ST_STB, 0);
    chk({tag, "_busy_gap"}, bus.BUSY, 1);
    tick();
    take_status("F", tag);
    check_regs(tag);
  endtask

  initial begin
    logic [7:0]  op;
    logic [7:0]  len;
    logic [31:0] addr;
    int          d;

    bus.RX_STB = 1'b0;
    bus.RX_DAT = 8'h00;
    bus.WR_ACK = 1'b0;
    bus.RD_ACK = 1'b0;
    bus.ST_ACK = 1'b0;
    repeat (3) tick();
    chk("rst_wr_stb", bus.WR_STB, 0);
    chk("rst_rd_stb", bus.RD_STB, 0);
    chk("rst_st_stb", bus.ST_STB, 0);
    chk("rst_st_dat", bus.ST_DAT, 0);
    chk("rst_busy", bus.BUSY, 0);
    check_regs("rst");
    rst_n = 1'b1;
    tick();

    do_frame("w", 32'h0000_1600, 8'd10, 5, 0, 1'b0, "write");
    do_frame("r", 32'h1234_5678, 8'd3, 0, 0, 1'b0, "rd_tmo");
    do_frame("x", 32'h0, 8'd0, 0, 0, 1'b0, "unknown");
    do_frame("w", 32'h0000_0001, 8'd0, 1, 0, 1'b0, "len0");
    gap_abort("r", 2, "gap_addr");
    do_frame("r", 32'h0000_0005, 8'd1, 3, 0, 1'b0, "after_gap");
    do_frame("r", 32'hCAFE_0042, 8'd200, TMO, 0, 1'b1, "ack_last");
    do_frame("w", 32'h0BAD_F00D, 8'd7, TMO + 1, 0, 1'b1, "ack_late");
    do_frame("w", 32'h0000_0099, 8'd1, 1, 0, 1'b0, "ack_first");
    gap_abort("w", 4, "gap_len");
    do_frame("r", 32'hA5A5_5A5A, 8'd255, 2, BT - 1, 1'b1, "gap_edge");

    // asynchronous reset in the middle of an outstanding write request
    send_byte("w");
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h07);
    chk("pre_rst_stb", bus.WR_STB, 1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    m_wr_addr = '0;
    m_wr_len  = '0;
    m_rd_addr = '0;
    m_rd_len  = '0;
    chk("arst_wr_stb", bus.WR_STB, 0);
    chk("arst_rd_stb", bus.RD_STB, 0);
    chk("arst_st_stb", bus.ST_STB, 0);
    chk("arst_st_dat", bus.ST_DAT, 0);
    chk("arst_busy", bus.BUSY, 0);
    check_regs("arst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_st_stb", bus.ST_STB, 0);
      chk("post_rst_busy", bus.BUSY, 0);
    end

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 9))
        0:       op = 8'($urandom);
        1, 2, 3, 4: op = "w";
        default: op = "r";
      endcase
      if (op != "w" && op != "r" && op != "?") op = "?";
      addr = $urandom;
      len  = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 5))
        0:       d = 0;
        1:       d = TMO;
        2:       d = TMO + 1;
        3:       d = 1;
        default: d = $urandom_range(1, TMO);
      endcase
      do_frame(op, addr, len, d, -1, 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
